bidir_pin_sched: RTL

Time-shares one bidirectional test pin (driven through an external BB tristate primitive) between two serial write requesters and one serial read requester. Grants the pin round-robin, serialises or samples DATA_BITS bits MSB-first at BIT_CLOCKS clocks per bit, and enforces a released-pin turnaround gap between transactions so the pin is never driven across an ownership change. Sits between the board-level BB instance (pin_o→I, pin_t→T, pin_i←O) and the test logic that exercises the pin.

---
 rtl/bidir_pin_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bidir_pin_sched.sv
// Round-robin scheduler for one bidirectional test pin shared by two serial
// writers and one serial reader, with a released-pin gap between owners.
module bidir_pin_sched #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_CLOCKS = 4,
    parameter int TURNAROUND = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           wr_req,
    input  logic [DATA_BITS-1:0] wr_data0,
    input  logic [DATA_BITS-1:0] wr_data1,
    input  logic                 rd_req,
    output logic [2:0]           grant,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 pin_o,
    output logic                 pin_t,
    input  logic                 pin_i,
    output logic [1:0]           state_dbg
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int CW = $clog2(BIT_CLOCKS);
    localparam int TW = $clog2(TURNAROUND + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CLK_LAST   = CW'(BIT_CLOCKS - 1);
    localparam logic [CW-1:0] CLK_PRE    = CW'(BIT_CLOCKS - 2);
    localparam logic [CW-1:0] CLK_SAMPLE = CW'(BIT_CLOCKS / 2);
    localparam logic [TW-1:0] GAP_LAST   = TW'(TURNAROUND - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [TW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic [2:0]           grant_q, grant_d;
    logic [1:0]           last_q, last_d;
    logic                 done_q, done_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 pin_o_q, pin_o_d;
    logic                 pin_t_q, pin_t_d;
    logic                 sync1_q, sync2_q;
    logic [2:0]           req;
    logic [1:0]           win;

    // Search starts at the requester after the previous winner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] w;
        w = 2'd0;
        case (last)
            2'd0:    if (r[1]) w = 2'd1; else if (r[2]) w = 2'd2; else w = 2'd0;
            2'd1:    if (r[2]) w = 2'd2; else if (r[0]) w = 2'd0; else w = 2'd1;
            default: if (r[0]) w = 2'd0; else if (r[1]) w = 2'd1; else w = 2'd2;
        endcase
        return w;
    endfunction

    assign req = {rd_req, wr_req};
    assign win = rr_pick(req, last_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        clk_cnt_d  = clk_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d   = S_XFER;
                    last_d    = win;
                    bit_cnt_d = '0;
                    clk_cnt_d = '0;
                    grant_d   = 3'b001 << win;
                    case (win)
                        2'd0:    shift_d = wr_data0;
                        2'd1:    shift_d = wr_data1;
                        default: shift_d = '0;
                    endcase
                end
            end
            S_XFER: begin
                if (grant_q[2] && clk_cnt_q == CLK_SAMPLE) begin
                    shift_d    = shift_q << 1;
                    shift_d[0] = sync2_q;
                end
                if (clk_cnt_q == CLK_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = S_GAP;
                        grant_d   = 3'b000;
                        gap_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (!grant_q[2]) shift_d = shift_q << 1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
                // Registered outputs: raise done one cycle early so it lands in the last XFER cycle.
                if (bit_cnt_q == BIT_LAST && clk_cnt_q == CLK_PRE) begin
                    done_d = 1'b1;
                    if (grant_q[2]) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = shift_d;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
                else gap_cnt_d = gap_cnt_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        pin_t_d = !(state_d == S_XFER && !grant_d[2]);
        pin_o_d = pin_t_d ? 1'b1 : shift_d[DATA_BITS-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            clk_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
            grant_q    <= 3'b000;
            last_q     <= 2'd2;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            pin_o_q    <= 1'b1;
            pin_t_q    <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            clk_cnt_q  <= clk_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            pin_o_q    <= pin_o_d;
            pin_t_q    <= pin_t_d;
            sync1_q    <= pin_i;
            sync2_q    <= sync1_q;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign pin_o     = pin_o_q;
    assign pin_t     = pin_t_q;
    assign state_dbg = state_q;

endmodule
